// File: rtl/mux_rr_sched.sv
// Round-robin arbiter that drives the select of an external 32:1 2-bit mux,
// captures the returned data and presents it with a valid/ready handshake.
module mux_rr_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] req,
  input  logic [1:0]  mux_out,
  output logic [4:0]  sel,
  output logic [31:0] req_ack,
  output logic [1:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_idx,
  input  logic        cfg_mask,
  output logic        busy,
  output logic [7:0]  txn_cnt
);

  typedef enum logic [1:0] {IDLE, SAMPLE, HOLD} state_t;

  state_t      state;
  logic [4:0]  ptr;
  logic [31:0] mask;
  logic [31:0] eligible;
  logic        found;
  logic [4:0]  pick_idx;

  assign eligible = req & ~mask;

  // First eligible index at or above ptr, wrapping 31 -> 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found    = 1'b0;
    pick_idx = ptr;
    for (int i = 0; i < 32; i++) begin
      if (!found && eligible[ptr + 5'(i)]) begin
        found    = 1'b1;
        pick_idx = ptr + 5'(i);
      end
    end
  end

  // The mask is a small flop array, so it is cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (cfg_we) begin
      mask[cfg_idx] <= cfg_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // sees the pre-edge values of its neighbours.
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      ptr       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      req_ack   <= '0;
      txn_cnt   <= '0;
      busy      <= 1'b0;
    end else begin
      req_ack <= '0;
      unique case (state)
        IDLE: begin
          if (en && found) begin
            sel   <= pick_idx;
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          out_data       <= mux_out;
          out_valid      <= 1'b1;
          req_ack[sel]   <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= sel + 5'd1;
            txn_cnt   <= txn_cnt + 8'd1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: expected grants are queued by the stimulus
// and consumed by a monitor that fires on every req_ack pulse.
module tb_mux_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] req;
  logic [1:0]  mux_out;
  logic [4:0]  sel;
  logic [31:0] req_ack;
  logic [1:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_we;
  logic [4:0]  cfg_idx;
  logic        cfg_mask;
  logic        busy;
  logic [7:0]  txn_cnt;

  typedef struct {
    logic [4:0] sel;
    logic [1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Stand-in for the external mux: input i carries ~i[1:0].
  assign mux_out = ~sel[1:0];

  mux_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_out(mux_out),
    .sel(sel), .req_ack(req_ack), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_mask(cfg_mask), .busy(busy), .txn_cnt(txn_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] mux_val(input logic [4:0] idx);
    return ~idx[1:0];
  endfunction

  task automatic push(input logic [4:0] s);
    exp_t e;
    e.sel  = s;
    e.data = mux_val(s);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every grant pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && req_ack != 32'd0) begin
      exp_t e;
      check("ack_onehot", 32'($onehot(req_ack)), 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_ack", req_ack, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_ack", req_ack, 32'd1 << e.sel);
        check("sb_sel", 32'(sel), 32'(e.sel));
        check("sb_data", 32'(out_data), 32'(e.data));
        check("sb_valid", 32'(out_valid), 32'd1);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_mask = 1'b0;
    #12;
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack", req_ack, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(txn_cnt), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on 5; req drops after selection and the transfer still completes.
    @(negedge clk);
    en = 1'b1; req = 32'd1 << 5;
    push(5'd5);
    tick();
    check("single_sel", 32'(sel), 32'd5);
    check("single_busy", 32'(busy), 32'd1);
    check("single_valid_early", 32'(out_valid), 32'd0);
    req = '0;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'b10);
    check("single_ack", req_ack, 32'd1 << 5);
    tick();
    check("single_done", 32'(out_valid), 32'd0);
    check("single_cnt", 32'(txn_cnt), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Fairness: all requesting from ptr=0 walks 0..31 and wraps back to 0.
    do_reset();
    req = '1;
    for (int k = 0; k < 33; k++) begin
      push(5'(k));
      tick();
      check("rr_sel", 32'(sel), 32'(k % 32));
      if (k == 32) req = '0;
      tick();
      tick();
      if (k == 31) check("rr_cnt32", 32'(txn_cnt), 32'd32);
    end

    // Backpressure: ptr=1, only requester 3; req changes and en drops during HOLD.
    out_ready = 1'b0;
    req = 32'd1 << 3;
    push(5'd3);
    tick();
    check("bp_sel", 32'(sel), 32'd3);
    tick();
    req = 32'd1 << 9;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(mux_val(5'd3)));
      check("bp_sel_hold", 32'(sel), 32'd3);
      check("bp_no_ack", req_ack, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_done", 32'(out_valid), 32'd0);
    tick();
    check("bp_en_blocks", 32'(busy), 32'd0);
    req = '0;
    en = 1'b1;

    // Masking: requester 12 excluded; 13 wins when both ask.
    cfg_we = 1'b1; cfg_idx = 5'd12; cfg_mask = 1'b1;
    tick();
    cfg_we = 1'b0;
    req = 32'd1 << 12;
    tick();
    tick();
    check("mask_busy", 32'(busy), 32'd0);
    check("mask_ack", req_ack, 32'd0);
    req = (32'd1 << 12) | (32'd1 << 13);
    push(5'd13);
    tick();
    check("mask_sel", 32'(sel), 32'd13);
    req = '0;
    tick();
    tick();

    // txn_cnt wraps after 256 transfers.
    do_reset();
    req = '1;
    for (int k = 0; k < 256; k++) begin
      push(5'(k % 32));
      tick();
      if (k == 255) req = '0;
      tick();
      tick();
      if (k == 254) check("cnt_255", 32'(txn_cnt), 32'd255);
    end
    check("cnt_wrap", 32'(txn_cnt), 32'd0);

    // Asynchronous reset mid-HOLD.
    do_reset();
    out_ready = 1'b0;
    req = 32'd1 << 7;
    push(5'd7);
    tick();
    req = '0;
    tick();
    tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cnt", 32'(txn_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
